// File: rtl/msrv32_dmem_ahb_master.sv
// Data-memory AHB-Lite master: turns each load/store request into one single transfer.
// Optional bus-error handling is enabled with `define MSRV32_DMEM_ERR_EN.
module msrv32_dmem_ahb_master #(
  parameter int unsigned WAIT_CNT_W = 8
) (
  input  logic                  ms_riscv32_mp_clk_in,
  input  logic                  ms_riscv32_mp_rst_in,
  input  logic [31:0]           dmaddr_in,
  input  logic [31:0]           dmdata_in,
  input  logic [3:0]            dmwr_mask_in,
  input  logic                  dmwr_req_in,
  input  logic                  dmrd_req_in,
  output logic                  dm_stall_out,
  output logic [31:0]           dm_rdata_out,
  output logic                  dm_rdata_valid_out,
  output logic                  dm_err_out,
  output logic [WAIT_CNT_W-1:0] dm_wait_cnt_out,
  output logic [31:0]           ahb_haddr_out,
  output logic                  ahb_hwrite_out,
  output logic [2:0]            ahb_hsize_out,
  output logic [1:0]            ahb_htrans_out,
  output logic [31:0]           ahb_hwdata_out,
  input  logic [31:0]           ahb_hrdata_in,
  input  logic                  ahb_hready_in,
  input  logic                  ahb_hresp_in
);

`ifdef MSRV32_DMEM_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_ERR, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [31:0]             haddr_q, haddr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             hwdata_q, hwdata_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [2:0]              hsize_q, hsize_d;
  logic                    hwrite_q, hwrite_d;
  logic                    rd_q, rd_d;
  logic                    err_q, err_d;
  logic [WAIT_CNT_W-1:0]   wait_q, wait_d;

  logic [2:0]              wr_size;
  logic [1:0]              wr_off;
  logic                    err_resp;

  assign err_resp = ErrEn & ahb_hresp_in;

  // Narrow transfers only for the canonical byte/halfword lane masks.
  always_comb begin
    wr_size = 3'b010;
    wr_off  = 2'b00;
    case (dmwr_mask_in)
      4'b0001: begin wr_size = 3'b000; wr_off = 2'b00; end
      4'b0010: begin wr_size = 3'b000; wr_off = 2'b01; end
      4'b0100: begin wr_size = 3'b000; wr_off = 2'b10; end
      4'b1000: begin wr_size = 3'b000; wr_off = 2'b11; end
      4'b0011: begin wr_size = 3'b001; wr_off = 2'b00; end
      4'b1100: begin wr_size = 3'b001; wr_off = 2'b10; end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    haddr_d  = haddr_q;
    wdata_d  = wdata_q;
    hwdata_d = hwdata_q;
    rdata_d  = rdata_q;
    hsize_d  = hsize_q;
    hwrite_d = hwrite_q;
    rd_d     = rd_q;
    err_d    = err_q;
    wait_d   = wait_q;

    if ((state_q == S_ADDR || state_q == S_DATA || state_q == S_ERR) &&
        !ahb_hready_in && wait_q != '1)
      wait_d = wait_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        err_d = 1'b0;
        if (dmwr_req_in) begin
          rd_d     = 1'b0;
          haddr_d  = {dmaddr_in[31:2], wr_off};
          hsize_d  = wr_size;
          hwrite_d = 1'b1;
          wdata_d  = dmdata_in;
          state_d  = (dmwr_mask_in == 4'b0000) ? S_DONE : S_ADDR;
        end else if (dmrd_req_in) begin
          rd_d     = 1'b1;
          haddr_d  = {dmaddr_in[31:2], 2'b00};
          hsize_d  = 3'b010;
          hwrite_d = 1'b0;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        if (ahb_hready_in) begin
          state_d = S_DATA;
          if (hwrite_q) hwdata_d = wdata_q;
        end
      end
      S_DATA: begin
        if (err_resp && !ahb_hready_in) begin
          state_d = S_ERR;
        end else if (ahb_hready_in) begin
          if (rd_q) rdata_d = ahb_hrdata_in;
          state_d = S_DONE;
        end
      end
      S_ERR: begin
        if (ahb_hready_in) begin
          err_d   = 1'b1;
          if (rd_q) rdata_d = '0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q  <= S_IDLE;
      haddr_q  <= '0;
      wdata_q  <= '0;
      hwdata_q <= '0;
      rdata_q  <= '0;
      hsize_q  <= '0;
      hwrite_q <= 1'b0;
      rd_q     <= 1'b0;
      err_q    <= 1'b0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      wdata_q  <= wdata_d;
      hwdata_q <= hwdata_d;
      rdata_q  <= rdata_d;
      hsize_q  <= hsize_d;
      hwrite_q <= hwrite_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
      wait_q   <= wait_d;
    end
  end

  assign dm_stall_out       = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_ERR) ||
                              ((state_q == S_IDLE) && (dmwr_req_in || dmrd_req_in));
  assign dm_rdata_out       = rdata_q;
  assign dm_rdata_valid_out = (state_q == S_DONE) && rd_q;
  assign dm_err_out         = ErrEn && (state_q == S_DONE) && err_q;
  assign dm_wait_cnt_out    = wait_q;
  assign ahb_haddr_out      = haddr_q;
  assign ahb_hwrite_out     = hwrite_q;
  assign ahb_hsize_out      = hsize_q;
  assign ahb_htrans_out     = (state_q == S_ADDR) ? 2'b10 : 2'b00;
  assign ahb_hwdata_out     = hwdata_q;

endmodule

// File: tb/tb_msrv32_dmem_ahb_master.sv
// Directed bench for msrv32_dmem_ahb_master; a small AHB slave model drives HREADY/HRESP per phase.
module tb_msrv32_dmem_ahb_master;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dmaddr, dmdata;
  logic [3:0]  dmmask;
  logic        dmwr, dmrd;
  logic        stall, valid, err;
  logic [31:0] rdata;
  logic [7:0]  wcnt;
  logic [31:0] haddr, hwdata, hrdata;
  logic        hwrite, hready, hresp;
  logic [2:0]  hsize;
  logic [1:0]  htrans;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] r_haddr, r_hwdata, r_rdata;
  logic [2:0]  r_hsize;
  logic        r_hwrite, r_err, r_stable;
  int unsigned r_stall, r_nonseq, r_valid;

  always #5 clk = ~clk;

  msrv32_dmem_ahb_master #(.WAIT_CNT_W(8)) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .dmaddr_in            (dmaddr),
    .dmdata_in            (dmdata),
    .dmwr_mask_in         (dmmask),
    .dmwr_req_in          (dmwr),
    .dmrd_req_in          (dmrd),
    .dm_stall_out         (stall),
    .dm_rdata_out         (rdata),
    .dm_rdata_valid_out   (valid),
    .dm_err_out           (err),
    .dm_wait_cnt_out      (wcnt),
    .ahb_haddr_out        (haddr),
    .ahb_hwrite_out       (hwrite),
    .ahb_hsize_out        (hsize),
    .ahb_htrans_out       (htrans),
    .ahb_hwdata_out       (hwdata),
    .ahb_hrdata_in        (hrdata),
    .ahb_hready_in        (hready),
    .ahb_hresp_in         (hresp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request; slave inserts aw address waits and dw data waits, or a two-cycle error.
  task automatic run_xfer(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [31:0] wdat, input logic [3:0] mask,
                          input int unsigned aw, input int unsigned dw,
                          input logic [31:0] bus_rdata, input logic err_resp);
    int unsigned phase, acnt, dcnt;
    bit done;
    r_stall = 0; r_nonseq = 0; r_valid = 0; r_stable = 1'b1; r_err = 1'b0;
    r_rdata = '0; r_haddr = '0; r_hsize = '0; r_hwrite = 1'b0; r_hwdata = '0;
    phase = 0; acnt = 0; dcnt = 0; done = 1'b0;
    @(posedge clk); #1;
    dmaddr = addr; dmdata = wdat; dmmask = mask; dmwr = wr; dmrd = rd;
    hready = 1'b1; hresp = 1'b0; hrdata = bus_rdata;
    for (int c = 0; c < int'(aw + dw) + 12 && !done; c++) begin
      @(negedge clk);
      if (stall) r_stall++;
      if (valid) r_valid++;
      if (htrans == 2'b10) r_nonseq++;
      case (phase)
        1: begin
          if (acnt == 0) {r_haddr, r_hsize, r_hwrite} = {haddr, hsize, hwrite};
          else if ({haddr, hsize, hwrite} !== {r_haddr, r_hsize, r_hwrite}) r_stable = 1'b0;
          if (htrans !== 2'b10) r_stable = 1'b0;
          hready = (acnt == aw);
          acnt++;
        end
        2: begin
          if (dcnt == 0) r_hwdata = hwdata;
          else if (hwdata !== r_hwdata || htrans !== 2'b00) r_stable = 1'b0;
          if (err_resp) begin hresp = 1'b1; hready = 1'b0; end
          else hready = (dcnt == dw);
          dcnt++;
        end
        4: begin hresp = 1'b1; hready = 1'b1; end
        3: begin r_err = err; r_rdata = rdata; end
        default: ;
      endcase
      @(posedge clk); #1;
      dmwr = 1'b0; dmrd = 1'b0;
      case (phase)
        0: phase = (wr && mask == 4'b0000) ? 3 : 1;
        1: if (hready) phase = 2;
        2: if (err_resp) phase = 4; else if (hready) phase = 3;
        4: phase = 3;
        3: done = 1'b1;
        default: ;
      endcase
    end
    hready = 1'b1; hresp = 1'b0;
    if (!done) check("xfer_timeout", 32'd0, 32'd1);
    @(negedge clk);
    if (valid) r_valid++;
    check("err_after_done", 32'(err), 32'd0);
  endtask

  initial begin
    rst = 1'b1; dmaddr = '0; dmdata = '0; dmmask = '0; dmwr = 1'b0; dmrd = 1'b0;
    hrdata = '0; hready = 1'b1; hresp = 1'b0;
    #12;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_htrans", 32'(htrans), 32'd0);
    check("rst_haddr", haddr, 32'h0);
    check("rst_hwdata", hwdata, 32'h0);
    check("rst_hsize_hwrite", {28'd0, hsize, hwrite}, 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_valid_err", {30'd0, valid, err}, 32'd0);
    check("rst_wcnt", 32'(wcnt), 32'd0);
    rst = 1'b0;

    run_xfer(1'b0, 1'b1, 32'h0000_1004, 32'h0, 4'b0000, 0, 0, 32'hDEAD_BEEF, 1'b0);
    check("rd_haddr", r_haddr, 32'h0000_1004);
    check("rd_hsize", 32'(r_hsize), 32'd2);
    check("rd_hwrite", 32'(r_hwrite), 32'd0);
    check("rd_stall", 32'(r_stall), 32'd3);
    check("rd_valid", 32'(r_valid), 32'd1);
    check("rd_rdata", r_rdata, 32'hDEAD_BEEF);
    check("rd_nonseq", 32'(r_nonseq), 32'd1);

    run_xfer(1'b1, 1'b0, 32'h0000_2000, 32'h00AB_0000, 4'b0100, 0, 0, 32'h0, 1'b0);
    check("bw_haddr", r_haddr, 32'h0000_2002);
    check("bw_hsize", 32'(r_hsize), 32'd0);
    check("bw_hwrite", 32'(r_hwrite), 32'd1);
    check("bw_hwdata", r_hwdata, 32'h00AB_0000);
    check("bw_valid", 32'(r_valid), 32'd0);
    check("bw_stall", 32'(r_stall), 32'd3);
    check("bw_rdata_hold", rdata, 32'hDEAD_BEEF);

    run_xfer(1'b1, 1'b0, 32'h0000_3000, 32'h1234_0000, 4'b1100, 2, 3, 32'h0, 1'b0);
    check("hw_haddr", r_haddr, 32'h0000_3002);
    check("hw_hsize", 32'(r_hsize), 32'd1);
    check("hw_stable", 32'(r_stable), 32'd1);
    check("hw_stall", 32'(r_stall), 32'd8);
    check("hw_wcnt", 32'(wcnt), 32'd5);
    check("hw_hwdata", r_hwdata, 32'h1234_0000);
    check("hw_nonseq", 32'(r_nonseq), 32'd3);

    run_xfer(1'b1, 1'b0, 32'h0000_5000, 32'hFFFF_FFFF, 4'b0000, 0, 0, 32'h0, 1'b0);
    check("m0_nonseq", 32'(r_nonseq), 32'd0);
    check("m0_stall", 32'(r_stall), 32'd1);
    check("m0_valid", 32'(r_valid), 32'd0);

    run_xfer(1'b1, 1'b1, 32'h0000_6004, 32'hCAFE_F00D, 4'b1000, 0, 0, 32'h1111_1111, 1'b0);
    check("both_hwrite", 32'(r_hwrite), 32'd1);
    check("both_haddr", r_haddr, 32'h0000_6007);
    check("both_hsize", 32'(r_hsize), 32'd0);
    check("both_nonseq", 32'(r_nonseq), 32'd1);
    check("both_valid", 32'(r_valid), 32'd0);
    check("both_rdata_hold", rdata, 32'hDEAD_BEEF);

    run_xfer(1'b1, 1'b0, 32'h0000_7008, 32'h0012_3400, 4'b0110, 0, 0, 32'h0, 1'b0);
    check("ww_haddr", r_haddr, 32'h0000_7008);
    check("ww_hsize", 32'(r_hsize), 32'd2);

    run_xfer(1'b0, 1'b1, 32'h0000_8000, 32'h0, 4'b0000, 0, 300, 32'h55AA_55AA, 1'b0);
    check("sat_wcnt", 32'(wcnt), 32'd255);
    check("sat_rdata", r_rdata, 32'h55AA_55AA);
    check("sat_stall", 32'(r_stall), 32'd303);

    @(posedge clk); #1;
    dmaddr = 32'h0000_4000; dmrd = 1'b1; hready = 1'b1;
    @(posedge clk); #1;
    dmrd = 1'b0;
    @(posedge clk); #1;
    hready = 1'b0;
    @(negedge clk);
    check("mid_stall", 32'(stall), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_stall", 32'(stall), 32'd0);
    check("arst_haddr", haddr, 32'h0);
    check("arst_rdata", rdata, 32'h0);
    check("arst_wcnt", 32'(wcnt), 32'd0);
    check("arst_valid", 32'(valid), 32'd0);
    @(negedge clk);
    rst = 1'b0; hready = 1'b1;
    r_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (valid) r_valid++;
    end
    check("arst_no_pulse", 32'(r_valid), 32'd0);

    run_xfer(1'b0, 1'b1, 32'h0000_9000, 32'h0, 4'b0000, 0, 0, 32'hA5A5_A5A5, 1'b1);
    check("er_valid", 32'(r_valid), 32'd1);
    check("er_stall", 32'(r_stall), 32'd4);
`ifdef MSRV32_DMEM_ERR_EN
    check("er_err", 32'(r_err), 32'd1);
    check("er_rdata", r_rdata, 32'h0);
`else
    check("er_err", 32'(r_err), 32'd0);
    check("er_rdata", r_rdata, 32'hA5A5_A5A5);
`endif
    run_xfer(1'b0, 1'b1, 32'h0000_9004, 32'h0, 4'b0000, 0, 0, 32'h0BAD_F00D, 1'b0);
    check("post_err", 32'(r_err), 32'd0);
    check("post_rdata", r_rdata, 32'h0BAD_F00D);
    check("post_valid", 32'(r_valid), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
